// File: rtl/multi_adt7410_pkg.sv
// Shared types and ADT7410 register constants for the multi-channel poller.
package multi_adt7410_pkg;

   localparam int unsigned MAX_CHANNELS = 4;
   localparam int unsigned IDX_W        = 2;

   localparam logic [7:0] REG_TEMP    = 8'h00;
   localparam logic [7:0] REG_CFG     = 8'h03;
   localparam logic [7:0] CFG_ONESHOT = 8'h20;
   localparam logic [7:0] READ_COUNT  = 8'd2;

   typedef enum logic [3:0] {
      ST_DISABLED,
      ST_IDLE,
      ST_CFG_LOAD,
      ST_CFG_START,
      ST_CFG_WAIT,
      ST_CONV_WAIT,
      ST_PTR_LOAD,
      ST_PTR_START,
      ST_PTR_WAIT,
      ST_RD_LOAD,
      ST_RD_START,
      ST_RD_WAIT,
      ST_FETCH0,
      ST_FETCH1,
      ST_COMPARE,
      ST_ROUND_END
   } state_t;

   // Unsigned distance between two samples, one bit wider so it never wraps.
   function automatic logic [16:0] abs_diff(input logic [15:0] a, input logic [15:0] b);
      if (a >= b) return {1'b0, a} - {1'b0, b};
      else        return {1'b0, b} - {1'b0, a};
   endfunction

endpackage

// File: rtl/multi_adt7410_poller_wait_counter.sv
// Loadable down-counter with a zero flag; used for the round period and the conversion wait.
module wait_counter
   import multi_adt7410_pkg::*;
#(
   parameter int unsigned Width = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             en,
   input  logic [Width-1:0] load_value,
   output logic             zero_c
);

   logic [Width-1:0] count_q;

   // Load has priority; decrement stops at zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else if (load) begin
         count_q <= load_value;
      end else if (en && (count_q != '0)) begin
         count_q <= count_q - Width'(1);
      end
   end

   assign zero_c = (count_q == '0);

endmodule

// File: rtl/multi_adt7410_poller.sv
// Polls NumChannels ADT7410 sensors through one I2C master, one-shot per round, with change IRQ.
module multi_adt7410_poller
   import multi_adt7410_pkg::*;
#(
   parameter int unsigned NumChannels = 2,
   parameter logic [6:0]  BaseAddr    = 7'h48,
   parameter int unsigned WaitWidth   = 32
) (
   input  logic                      Clk_i,
   input  logic                      Reset_i,
   input  logic                      Enable_i,
   output logic                      CpuIntr_o,
   output logic                      Error_o,
   output logic [NumChannels-1:0]    ChangedMask_o,
   output logic [16*NumChannels-1:0] SensorValues_o,
   output logic                      I2C_ReceiveSend_n_o,
   output logic [7:0]                I2C_ReadCount_o,
   output logic                      I2C_StartProcess_o,
   input  logic                      I2C_Busy_i,
   output logic                      I2C_FIFOWrite_o,
   output logic [7:0]                I2C_Data_o,
   output logic                      I2C_FIFOReadNext_o,
   input  logic [7:0]                I2C_Data_i,
   input  logic                      I2C_Error_i,
   input  logic [WaitWidth-1:0]      PeriodPreset_i,
   input  logic [WaitWidth-1:0]      WaitPreset_i,
   input  logic [15:0]               Threshold_i
);

   state_t                           state_q, state_nxt;
   logic [IDX_W-1:0]                 idx_q, idx_nxt;
   logic [1:0]                       byte_q, byte_nxt;
   logic [MAX_CHANNELS-1:0]          round_mask_q, round_mask_nxt;
   logic [NumChannels-1:0]           changed_q, changed_nxt;
   logic [MAX_CHANNELS-1:0][15:0]    values_q, values_nxt;
   logic [15:0]                      rx_q, rx_nxt;
   logic                             error_q, error_nxt;
   logic                             intr_q, intr_nxt;
   logic                             fifo_write_q, fifo_write_nxt;
   logic [7:0]                       data_q, data_nxt;
   logic                             start_q, start_nxt;
   logic                             rs_n_q, rs_n_nxt;
   logic [7:0]                       read_count_q, read_count_nxt;
   logic                             read_next_q, read_next_nxt;

   logic                             period_load, period_en, period_zero;
   logic                             conv_load, conv_en, conv_zero;
   logic                             abort;
   logic [6:0]                       addr_nxt;
   logic [16:0]                      delta;

   wait_counter #(.Width(WaitWidth)) u_period (
      .clk        (Clk_i),
      .rst        (Reset_i),
      .load       (period_load),
      .en         (period_en),
      .load_value (PeriodPreset_i),
      .zero_c     (period_zero)
   );

   wait_counter #(.Width(WaitWidth)) u_conv (
      .clk        (Clk_i),
      .rst        (Reset_i),
      .load       (conv_load),
      .en         (conv_en),
      .load_value (WaitPreset_i),
      .zero_c     (conv_zero)
   );

   // Next-state, datapath updates, and next values of the registered I2C/CPU outputs.
   always_comb begin
      state_nxt      = state_q;
      idx_nxt        = idx_q;
      byte_nxt       = byte_q;
      round_mask_nxt = round_mask_q;
      changed_nxt    = changed_q;
      values_nxt     = values_q;
      rx_nxt         = rx_q;
      error_nxt      = error_q;
      intr_nxt       = 1'b0;
      period_load    = 1'b0;
      period_en      = 1'b0;
      conv_load      = 1'b0;
      conv_en        = 1'b0;
      abort          = 1'b0;
      delta          = abs_diff(rx_q, values_q[idx_q]);

      if (!Enable_i) begin
         state_nxt      = ST_DISABLED;
         error_nxt      = 1'b0;
         idx_nxt        = '0;
         byte_nxt       = '0;
         round_mask_nxt = '0;
      end else begin
         case (state_q)
            ST_DISABLED: begin
               state_nxt   = ST_IDLE;
               period_load = 1'b1;
            end
            ST_IDLE: begin
               if (period_zero) begin
                  state_nxt = ST_CFG_LOAD;
                  idx_nxt   = '0;
               end else begin
                  period_en = 1'b1;
               end
            end
            ST_CFG_LOAD: begin
               if (byte_q == 2'd2) begin
                  byte_nxt  = '0;
                  state_nxt = ST_CFG_START;
               end else begin
                  byte_nxt = byte_q + 2'd1;
               end
            end
            ST_CFG_START: if (I2C_Busy_i) state_nxt = ST_CFG_WAIT;
            ST_CFG_WAIT: begin
               if (I2C_Error_i) begin
                  abort = 1'b1;
               end else if (!I2C_Busy_i) begin
                  state_nxt = ST_CONV_WAIT;
                  conv_load = 1'b1;
               end
            end
            ST_CONV_WAIT: begin
               if (I2C_Error_i)    abort = 1'b1;
               else if (conv_zero) state_nxt = ST_PTR_LOAD;
               else                conv_en = 1'b1;
            end
            ST_PTR_LOAD: begin
               if (byte_q == 2'd1) begin
                  byte_nxt  = '0;
                  state_nxt = ST_PTR_START;
               end else begin
                  byte_nxt = byte_q + 2'd1;
               end
            end
            ST_PTR_START: if (I2C_Busy_i) state_nxt = ST_PTR_WAIT;
            ST_PTR_WAIT: begin
               if (I2C_Error_i)      abort = 1'b1;
               else if (!I2C_Busy_i) state_nxt = ST_RD_LOAD;
            end
            ST_RD_LOAD:  state_nxt = ST_RD_START;
            ST_RD_START: if (I2C_Busy_i) state_nxt = ST_RD_WAIT;
            ST_RD_WAIT: begin
               if (I2C_Error_i)      abort = 1'b1;
               else if (!I2C_Busy_i) state_nxt = ST_FETCH0;
            end
            ST_FETCH0: begin
               rx_nxt    = {I2C_Data_i, rx_q[7:0]};
               state_nxt = ST_FETCH1;
            end
            ST_FETCH1: begin
               rx_nxt    = {rx_q[15:8], I2C_Data_i};
               state_nxt = ST_COMPARE;
            end
            ST_COMPARE: begin
               if (delta > {1'b0, Threshold_i}) begin
                  values_nxt[idx_q]     = rx_q;
                  round_mask_nxt[idx_q] = 1'b1;
               end
               if (idx_q == IDX_W'(NumChannels - 1)) begin
                  state_nxt = ST_ROUND_END;
               end else begin
                  idx_nxt   = idx_q + IDX_W'(1);
                  state_nxt = ST_CFG_LOAD;
               end
            end
            ST_ROUND_END: begin
               changed_nxt    = round_mask_q[NumChannels-1:0];
               intr_nxt       = |round_mask_q;
               round_mask_nxt = '0;
               idx_nxt        = '0;
               period_load    = 1'b1;
               state_nxt      = ST_IDLE;
            end
            default: state_nxt = ST_DISABLED;
         endcase

         // Any master error while waiting drops the whole round.
         if (abort) begin
            error_nxt      = 1'b1;
            round_mask_nxt = '0;
            idx_nxt        = '0;
            byte_nxt       = '0;
            period_load    = 1'b1;
            state_nxt      = ST_IDLE;
         end
      end

      // Outputs are decoded from the next state so the registers line up with the state.
      addr_nxt       = BaseAddr + 7'(idx_nxt);
      fifo_write_nxt = 1'b0;
      data_nxt       = 8'h00;
      start_nxt      = 1'b0;
      rs_n_nxt       = 1'b0;
      read_count_nxt = 8'h00;
      read_next_nxt  = 1'b0;
      case (state_nxt)
         ST_CFG_LOAD: begin
            fifo_write_nxt = 1'b1;
            if (byte_nxt == 2'd0)      data_nxt = {addr_nxt, 1'b0};
            else if (byte_nxt == 2'd1) data_nxt = REG_CFG;
            else                       data_nxt = CFG_ONESHOT;
         end
         ST_PTR_LOAD: begin
            fifo_write_nxt = 1'b1;
            data_nxt       = (byte_nxt == 2'd0) ? {addr_nxt, 1'b0} : REG_TEMP;
         end
         ST_RD_LOAD: begin
            fifo_write_nxt = 1'b1;
            data_nxt       = {addr_nxt, 1'b1};
         end
         ST_CFG_START, ST_PTR_START: start_nxt = 1'b1;
         ST_RD_START: begin
            start_nxt      = 1'b1;
            rs_n_nxt       = 1'b1;
            read_count_nxt = READ_COUNT;
         end
         ST_RD_WAIT: begin
            rs_n_nxt       = 1'b1;
            read_count_nxt = READ_COUNT;
         end
         ST_FETCH0, ST_FETCH1: read_next_nxt = 1'b1;
         default: ;
      endcase
   end

   // State, datapath and output registers.
   always_ff @(posedge Clk_i or posedge Reset_i) begin
      if (Reset_i) begin
         state_q      <= ST_DISABLED;
         idx_q        <= '0;
         byte_q       <= '0;
         round_mask_q <= '0;
         changed_q    <= '0;
         values_q     <= '0;
         rx_q         <= '0;
         error_q      <= 1'b0;
         intr_q       <= 1'b0;
         fifo_write_q <= 1'b0;
         data_q       <= '0;
         start_q      <= 1'b0;
         rs_n_q       <= 1'b0;
         read_count_q <= '0;
         read_next_q  <= 1'b0;
      end else begin
         state_q      <= state_nxt;
         idx_q        <= idx_nxt;
         byte_q       <= byte_nxt;
         round_mask_q <= round_mask_nxt;
         changed_q    <= changed_nxt;
         values_q     <= values_nxt;
         rx_q         <= rx_nxt;
         error_q      <= error_nxt;
         intr_q       <= intr_nxt;
         fifo_write_q <= fifo_write_nxt;
         data_q       <= data_nxt;
         start_q      <= start_nxt;
         rs_n_q       <= rs_n_nxt;
         read_count_q <= read_count_nxt;
         read_next_q  <= read_next_nxt;
      end
   end

   assign CpuIntr_o           = intr_q;
   assign Error_o             = error_q;
   assign ChangedMask_o       = changed_q;
   assign SensorValues_o      = values_q[NumChannels-1:0];
   assign I2C_ReceiveSend_n_o = rs_n_q;
   assign I2C_ReadCount_o     = read_count_q;
   assign I2C_StartProcess_o  = start_q;
   assign I2C_FIFOWrite_o     = fifo_write_q;
   assign I2C_Data_o          = data_q;
   assign I2C_FIFOReadNext_o  = read_next_q;

endmodule
